// File: rtl/systolic_array_os_if.sv
// -----------------------------------------------------------------------------
// systolic_array_os_if
// Job-control, beat-input and result-output signals of the output-stationary
// systolic array, bundled so the engine and its surroundings connect through
// one port.
//   master : drives start/k_len and the input beats, observes status/results
//   slave  : the array engine itself
// Signals:
//   start, k_len            job launch and depth K (sampled on acceptance)
//   busy, done              job in progress / one-cycle end-of-job pulse
//   in_valid, in_ready      beat handshake (ready only while loading)
//   data_in, weight_in      lane i = A[i][k], lane j = B[k][j]
//   out_valid, out_row,     one result row per cycle, C[out_row][j] in lane j
//   out_data
// -----------------------------------------------------------------------------
interface systolic_array_os_if #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 8
);
  localparam int ROW_W = ($clog2(ARRAY_SIZE) < 1) ? 1 : $clog2(ARRAY_SIZE);

  logic                             start;
  logic [K_WIDTH-1:0]               k_len;
  logic                             busy;
  logic                             in_valid;
  logic                             in_ready;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] data_in;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_in;
  logic                             out_valid;
  logic [ROW_W-1:0]                 out_row;
  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  out_data;
  logic                             done;

  modport master (
    output start, k_len, in_valid, data_in, weight_in,
    input  busy, in_ready, out_valid, out_row, out_data, done
  );

  modport slave (
    input  start, k_len, in_valid, data_in, weight_in,
    output busy, in_ready, out_valid, out_row, out_data, done
  );
endinterface

// File: rtl/systolic_array_os.sv
// -----------------------------------------------------------------------------
// systolic_array_os
// N x N output-stationary systolic matrix multiplier computing C = A * B for
// A (N x K) and B (K x N) with run-time K and signed operands. One A-column /
// B-row beat is accepted per cycle; rows of A are skewed by i cycles and
// columns of B by j cycles so that PE(i,j) sees matching k terms. After the
// last beat the array flushes for 2N-1 cycles and then drains one row of C
// per cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  slave side of systolic_array_os_if (handshake, operands, results)
// -----------------------------------------------------------------------------
module systolic_array_os #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  systolic_array_os_if.slave bus
);
  localparam int N     = ARRAY_SIZE;
  localparam int DW    = DATA_WIDTH;
  localparam int AW    = ACC_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ROW_W = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam int FW    = $clog2(2 * N);
  localparam logic [FW-1:0]    FLUSH_LAST = FW'(2 * N - 2);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [K_WIDTH-1:0]    r_k_len;
  logic [K_WIDTH-1:0]    r_beat_cnt;
  logic [FW-1:0]         r_flush_cnt;
  logic                  w_clear;
  logic                  w_accept;
  logic                  w_beat_last;
  logic                  w_acc_en;
  logic [ROW_W-1:0]      w_row_next;

  logic signed [DW-1:0]  w_a_lane [N];
  logic signed [DW-1:0]  w_b_lane [N];
  logic signed [DW-1:0]  w_a_edge [N];
  logic signed [DW-1:0]  w_b_edge [N];
  logic signed [DW-1:0]  r_a_pe   [N][N];
  logic signed [DW-1:0]  r_b_pe   [N][N];
  logic signed [PW-1:0]  w_prod   [N][N];
  logic [AW-1:0]         r_acc      [N][N];
  logic [AW-1:0]         w_acc_next [N][N];
  logic [N*AW-1:0]       w_row_mux;

  logic                  r_busy;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [ROW_W-1:0]      r_out_row;
  logic [N*AW-1:0]       r_out_data;
  logic                  r_done;

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    w_acc_en     = 1'b0;
    w_beat_last  = ((r_beat_cnt + K_WIDTH'(1)) == r_k_len);
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_clear = 1'b1;
          if (bus.k_len == '0) begin
            w_state_next = S_FLUSH;
          end else begin
            w_state_next = S_LOAD;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        w_accept = bus.in_valid;
        w_acc_en = 1'b1;
        if (bus.in_valid && w_beat_last) begin
          w_state_next = S_FLUSH;
        end else begin
          w_state_next = S_LOAD;
        end
      end
      S_FLUSH: begin
        w_acc_en = 1'b1;
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_next = S_OUT;
        end else begin
          w_state_next = S_FLUSH;
        end
      end
      S_OUT: begin
        if (r_out_row == ROW_LAST) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_OUT;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Row index that will be presented in the coming cycle.
  always_comb begin
    w_row_next = '0;
    if (r_state == S_OUT && w_state_next == S_OUT) begin
      w_row_next = r_out_row + ROW_W'(1);
    end else begin
      w_row_next = '0;
    end
  end

  // Edge lanes: accepted beat data, or zeros on a bubble so nothing is added.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (w_accept) begin
        w_a_lane[i] = bus.data_in[i*DW +: DW];
        w_b_lane[i] = bus.weight_in[i*DW +: DW];
      end else begin
        w_a_lane[i] = '0;
        w_b_lane[i] = '0;
      end
    end
  end

  // Lane i of A and lane i of B (column i) each get i cycles of delay.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign w_a_edge[gi] = w_a_lane[gi];
      assign w_b_edge[gi] = w_b_lane[gi];
    end else begin : g_chain
      logic signed [DW-1:0] r_a_sk [gi];
      logic signed [DW-1:0] r_b_sk [gi];

      // Skew shift chain, cleared on reset and at job start.
      always_ff @(posedge clk) begin
        if (!rst || w_clear) begin
          for (int s = 0; s < gi; s++) begin
            r_a_sk[s] <= '0;
            r_b_sk[s] <= '0;
          end
        end else begin
          r_a_sk[0] <= w_a_lane[gi];
          r_b_sk[0] <= w_b_lane[gi];
          for (int s = 1; s < gi; s++) begin
            r_a_sk[s] <= r_a_sk[s-1];
            r_b_sk[s] <= r_b_sk[s-1];
          end
        end
      end

      assign w_a_edge[gi] = r_a_sk[gi-1];
      assign w_b_edge[gi] = r_b_sk[gi-1];
    end
  end

  // PE operand registers: A flows right along a row, B flows down a column.
  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_a_pe[i][j] <= '0;
          r_b_pe[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        r_a_pe[i][0] <= w_a_edge[i];
        r_b_pe[0][i] <= w_b_edge[i];
        for (int j = 1; j < N; j++) begin
          r_a_pe[i][j] <= r_a_pe[i][j-1];
          r_b_pe[j][i] <= r_b_pe[j-1][i];
        end
      end
    end
  end

  // Full-precision signed products, sign-extended and added modulo 2^AW.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_prod[i][j] = PW'(r_a_pe[i][j]) * PW'(r_b_pe[i][j]);
        if (w_acc_en) begin
          w_acc_next[i][j] = r_acc[i][j] + AW'(w_prod[i][j]);
        end else begin
          w_acc_next[i][j] = r_acc[i][j];
        end
      end
    end
  end

  // Row mux taken from the post-update accumulators so the first row
  // already contains the final term added on the FLUSH->OUT edge.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_row_mux[j*AW +: AW] = w_acc_next[w_row_next][j];
    end
  end

  // Accumulator array; frozen outside LOAD/FLUSH by w_acc_en.
  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      r_acc <= w_acc_next;
    end
  end

  // State register and job counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_clear) begin
        r_k_len    <= bus.k_len;
        r_beat_cnt <= '0;
      end else if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + K_WIDTH'(1);
      end else begin
        r_beat_cnt <= r_beat_cnt;
      end
      if (r_state == S_FLUSH) begin
        r_flush_cnt <= r_flush_cnt + FW'(1);
      end else begin
        r_flush_cnt <= '0;
      end
    end
  end

  // Registered outputs, all derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_busy      <= (w_state_next != S_IDLE);
      r_in_ready  <= (w_state_next == S_LOAD);
      r_out_valid <= (w_state_next == S_OUT);
      r_out_row   <= w_row_next;
      r_done      <= (r_state == S_OUT) && (w_state_next == S_IDLE);
      if (w_state_next == S_OUT) begin
        r_out_data <= w_row_mux;
      end else begin
        r_out_data <= '0;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_row   = r_out_row;
  assign bus.out_data  = r_out_data;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_systolic_array_os.sv
// Self-checking bench for systolic_array_os (N=4). Expected results come from
// a plain sum-of-products model over the stored A/B matrices.
module tb_systolic_array_os;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 40;
  localparam int KW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [DW-1:0] a_mat [N][256];
  logic [DW-1:0] b_mat [256][N];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  systolic_array_os_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) bus ();

  systolic_array_os #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] (signed), modulo 2^AW.
  function automatic logic [AW-1:0] model_c(input int i, input int j, input int k_n);
    longint s;
    s = 0;
    for (int k = 0; k < k_n; k++)
      s += longint'($signed(a_mat[i][k])) * longint'($signed(b_mat[k][j]));
    return s[AW-1:0];
  endfunction

  // One complete job. mode: 0 back-to-back beats, 1 alternate bubbles, 2 random bubbles.
  task automatic run_job(input string name, input int k_n, input int mode, input bit b2b,
                         input bit poke, input bit chain, output int lat);
    int c0, e_cyc, idx, step, rows, guard, done_cyc;
    bit acc;
    lat = -1;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    bus.k_len = KW'(k_n);
    c0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    e_cyc = cyc;
    if (poke) begin
      bus.start = 1'b1;
      bus.k_len = 8'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    idx = 0; step = 0;
    while (idx < k_n && step < 4000) begin
      if (mode == 0) bus.in_valid = 1'b1;
      else if (mode == 1) bus.in_valid = (step % 2 == 0);
      else bus.in_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        bus.data_in[i*DW +: DW]   = a_mat[i][idx];
        bus.weight_in[i*DW +: DW] = b_mat[idx][i];
      end
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready_load: got %b want 1 (beat %0d)", name, bus.in_ready, idx);
        bus.in_valid = 1'b0;
        return;
      end
      acc = bus.in_valid;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        e_cyc = cyc;
      end
      step++;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s in_ready_after_last: got %b want 0", name, bus.in_ready);
    end
    rows = 0; guard = 0;
    while (rows < N && guard < 100) begin
      if (bus.out_valid === 1'b1) begin
        if (rows == 0) begin
          checks++;
          if (cyc != e_cyc + 2*N - 1) begin
            errors++;
            $display("FAIL %s first_row_time: got %0d want %0d", name, cyc - e_cyc, 2*N - 1);
          end
        end
        checks++;
        if (bus.out_row !== 2'(rows)) begin
          errors++;
          $display("FAIL %s out_row: got %0d want %0d", name, bus.out_row, rows);
        end
        for (int j = 0; j < N; j++) begin
          checks++;
          if (bus.out_data[j*AW +: AW] !== model_c(rows, j, k_n)) begin
            errors++;
            $display("FAIL %s C[%0d][%0d]: got %h want %h", name, rows, j,
                     bus.out_data[j*AW +: AW], model_c(rows, j, k_n));
          end
        end
        rows++;
      end
      guard++;
      @(negedge clk);
    end
    checks++;
    if (rows != N) begin
      errors++;
      $display("FAIL %s rows_timeout: got %0d rows want %0d", name, rows, N);
      return;
    end
    guard = 0;
    while (bus.done !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: got %b want 1", name, bus.done);
      return;
    end
    done_cyc = cyc;
    lat = done_cyc - c0;
    checks++;
    if (done_cyc != e_cyc + 3*N - 1) begin
      errors++;
      $display("FAIL %s done_time: got %0d want %0d after last beat", name, done_cyc - e_cyc, 3*N - 1);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s done_cycle_status: got busy=%b out_valid=%b want 0 0", name, bus.busy, bus.out_valid);
    end
    if (!chain) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse: got %b want 0", name, bus.done);
      end
    end
  endtask

  task automatic fill_random(input int k_n);
    for (int k = 0; k < k_n; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[i][k] = DW'($urandom);
        b_mat[k][i] = DW'($urandom);
      end
  endtask

  task automatic fill_identity();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[i][k] = (i == k) ? 16'd1 : 16'd0;
        b_mat[k][i] = DW'(4*k + i + 1);
      end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_row !== 2'd0 || bus.out_data !== '0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s reset_outputs: got busy=%b rdy=%b ov=%b row=%0d data=%h done=%b want all 0",
               name, bus.busy, bus.in_ready, bus.out_valid, bus.out_row, bus.out_data, bus.done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_held");
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_identity();
    int lat;
    fill_identity();
    run_job("identity", 4, 0, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL identity_latency: got %0d want 16", lat);
    end
  endtask

  task automatic test_signed();
    int lat;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[i][k] = 16'hFFFF;
        b_mat[k][i] = 16'h0003;
      end
    run_job("signed", 8, 0, 1'b0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_bubbles();
    int lat;
    fill_identity();
    run_job("bubbles", 4, 1, 1'b0, 1'b0, 1'b0, lat);
    fill_random(20);
    run_job("rand_bubbles", 20, 2, 1'b0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_k_zero();
    int lat, bad;
    fill_random(8);
    run_job("kzero", 0, 0, 1'b0, 1'b1, 1'b0, lat);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL kzero_second_job: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_wrap();
    int lat;
    for (int k = 0; k < 255; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[i][k] = 16'h7FFF;
        b_mat[k][i] = 16'h7FFF;
      end
    run_job("wrap", 255, 0, 1'b0, 1'b0, 1'b0, lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    fill_random(6);
    run_job("b2b_first", 6, 0, 1'b0, 1'b0, 1'b1, lat);
    fill_random(9);
    run_job("b2b_second", 9, 2, 1'b1, 1'b0, 1'b0, lat);
  endtask

  task automatic test_reset_mid();
    int lat, bad;
    fill_random(6);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_len = 8'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.data_in[i*DW +: DW]   = 16'h7FFF;
        bus.weight_in[i*DW +: DW] = 16'h1234;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_aborted: got %0d active cycles want 0", bad);
    end
    run_job("after_reset", 6, 0, 1'b0, 1'b0, 1'b0, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.weight_in = '0;
    test_reset();
    test_identity();
    test_signed();
    test_bubbles();
    test_k_zero();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
